layer_trainer: RTL and testbench

Training sequencer that drives one fully-connected learning layer (N inputs, M neurons) from the outside. It accepts one training sample per handshake and presents it to the layer's `in` / `expected_out` ports. It captures the forward result and computes the per-sample absolute error serially, then optionally issues one learn strobe and captures the layer's back-propagated `expected_in`. It sits between the sample source (testbench or upstream layer's expected_in path) and a layer instance, mirroring the layer's interface from the driving side.

---
 rtl/layer_trainer_if.sv | 47 ++++
 rtl/layer_trainer.sv | 150 +++++++++++++++
 tb/tb_layer_trainer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_trainer_if.sv
// ---------------------------------------------------------------------------
// layer_trainer_if
// Bundles the three channels of the training sequencer:
//   s_*  sample source -> trainer (valid/ready handshake, inputs, targets)
//   l_*  trainer <-> layer instance (strobes, presented sample, layer results)
//   r_*  trainer -> result consumer (valid/ready handshake, captured results)
// Modports:
//   slave  : the trainer itself
//   master : the environment around it (sample source, layer, consumer)
// Z is the zero2one_t width; vectors are packed [count][Z] arrays.
// ---------------------------------------------------------------------------
interface layer_trainer_if #(
  parameter int N = 16,
  parameter int M = 19,
  parameter int Z = 8
);
  logic                s_valid;
  logic                s_ready;
  logic [N-1:0][Z-1:0] s_in;
  logic [M-1:0][Z-1:0] s_target;
  logic                s_learn;

  logic                l_valid;
  logic                l_learn;
  logic [N-1:0][Z-1:0] l_in;
  logic [M-1:0][Z-1:0] l_expected_out;
  logic [M-1:0][Z-1:0] l_out;
  logic [N-1:0][Z-1:0] l_expected_in;

  logic                r_valid;
  logic                r_ready;
  logic [M-1:0][Z-1:0] r_out;
  logic [N-1:0][Z-1:0] r_expected_in;
  logic [Z+4:0]        r_error;

  modport slave (
    input  s_valid, s_in, s_target, s_learn, l_out, l_expected_in, r_ready,
    output s_ready, l_valid, l_learn, l_in, l_expected_out,
           r_valid, r_out, r_expected_in, r_error
  );

  modport master (
    output s_valid, s_in, s_target, s_learn, l_out, l_expected_in, r_ready,
    input  s_ready, l_valid, l_learn, l_in, l_expected_out,
           r_valid, r_out, r_expected_in, r_error
  );
endinterface

// File: rtl/layer_trainer.sv
// ---------------------------------------------------------------------------
// layer_trainer
// Drives one fully-connected learning layer from the outside: accepts a
// sample, fires one forward strobe, captures the layer output, accumulates
// the absolute error one neuron per cycle, optionally fires one learn strobe
// and captures the back-propagated expected_in, then presents the result.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high reset
//   bus    layer_trainer_if.slave (s_*, l_*, r_* channels)
// Parameters: N inputs, M neurons, LAT layer latency (>=1), Z value width.
// ---------------------------------------------------------------------------
module layer_trainer #(
  parameter int N   = 16,
  parameter int M   = 19,
  parameter int LAT = 1,
  parameter int Z   = 8
) (
  input logic            clock,
  input logic            reset,
  layer_trainer_if.slave bus
);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int EW = Z + 5;

  typedef enum logic [2:0] {
    IDLE, FWD, WAIT_F, ERR, LRN, WAIT_L, RESULT
  } state_e;

  state_e              state_q;
  logic                learn_q;
  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       idx_q;
  logic                l_valid_q;
  logic                l_learn_q;
  logic [N-1:0][Z-1:0] l_in_q;
  logic [M-1:0][Z-1:0] l_exp_out_q;
  logic                r_valid_q;
  logic [M-1:0][Z-1:0] r_out_q;
  logic [N-1:0][Z-1:0] r_exp_in_q;
  logic [EW-1:0]       r_error_q;

  // Absolute difference of the neuron currently addressed by idx_q: larger
  // minus smaller, so the subtraction never wraps.
  logic [Z-1:0]  tgt_sel;
  logic [Z-1:0]  out_sel;
  logic [Z-1:0]  abs_diff;
  logic [EW-1:0] r_error_d;

  assign tgt_sel   = l_exp_out_q[idx_q];
  assign out_sel   = r_out_q[idx_q];
  assign abs_diff  = (tgt_sel >= out_sel) ? (tgt_sel - out_sel) : (out_sel - tgt_sel);
  assign r_error_d = r_error_q + EW'(abs_diff);

  // Ready is masked by reset so a sample offered during reset is never taken.
  assign bus.s_ready        = (state_q == IDLE) && !reset;
  assign bus.l_valid        = l_valid_q;
  assign bus.l_learn        = l_learn_q;
  assign bus.l_in           = l_in_q;
  assign bus.l_expected_out = l_exp_out_q;
  assign bus.r_valid        = r_valid_q;
  assign bus.r_out          = r_out_q;
  assign bus.r_expected_in  = r_exp_in_q;
  assign bus.r_error        = r_error_q;

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      learn_q     <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      l_valid_q   <= 1'b0;
      l_learn_q   <= 1'b0;
      l_in_q      <= '0;
      l_exp_out_q <= '0;
      r_valid_q   <= 1'b0;
      r_out_q     <= '0;
      r_exp_in_q  <= '0;
      r_error_q   <= '0;
    end else begin
      // Strobes are single-cycle: default low, raised only on the entering edge.
      l_valid_q <= 1'b0;
      l_learn_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.s_valid) begin
            l_in_q      <= bus.s_in;
            l_exp_out_q <= bus.s_target;
            learn_q     <= bus.s_learn;
            l_valid_q   <= 1'b1;
            state_q     <= FWD;
          end
        end
        FWD: begin
          cnt_q   <= CW'(LAT - 1);
          state_q <= WAIT_F;
        end
        WAIT_F: begin
          if (cnt_q == '0) begin
            r_out_q   <= bus.l_out;
            r_error_q <= '0;
            idx_q     <= '0;
            state_q   <= ERR;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ERR: begin
          r_error_q <= r_error_d;
          if (idx_q == IW'(M - 1)) begin
            if (learn_q) begin
              l_valid_q <= 1'b1;
              l_learn_q <= 1'b1;
              state_q   <= LRN;
            end else begin
              r_exp_in_q <= '0;
              r_valid_q  <= 1'b1;
              state_q    <= RESULT;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        LRN: begin
          cnt_q   <= CW'(LAT - 1);
          state_q <= WAIT_L;
        end
        WAIT_L: begin
          if (cnt_q == '0) begin
            r_exp_in_q <= bus.l_expected_in;
            r_valid_q  <= 1'b1;
            state_q    <= RESULT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESULT: begin
          if (bus.r_ready) begin
            r_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_layer_trainer.sv
// ---------------------------------------------------------------------------
// tb_layer_trainer
// Self-checking bench for layer_trainer. A stub layer answers the forward
// and learn strobes one cycle later with patterns derived from the presented
// sample; the reference model derives the same patterns, the error sum and
// the cycle positions directly from the sample and the timing rules.
// A second instance with LAT=3 exercises reset during the learn wait.
// ---------------------------------------------------------------------------
module tb_layer_trainer;
  localparam int N  = 16;
  localparam int M  = 19;
  localparam int Z  = 8;
  localparam int LAT = 1;
  localparam int LAT3 = 3;

  typedef logic [N-1:0][Z-1:0] vin_t;
  typedef logic [M-1:0][Z-1:0] vout_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset3 = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   stub_mode = 0;

  always #5 clk = ~clk;

  layer_trainer_if #(.N(N), .M(M), .Z(Z)) bus ();
  layer_trainer_if #(.N(N), .M(M), .Z(Z)) bus3 ();

  layer_trainer #(.N(N), .M(M), .LAT(LAT), .Z(Z)) u_dut (
    .clock(clk), .reset(reset), .bus(bus.slave)
  );
  layer_trainer #(.N(N), .M(M), .LAT(LAT3), .Z(Z)) u_dut3 (
    .clock(clk), .reset(reset3), .bus(bus3.slave)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference patterns ----------------
  function automatic vout_t fwd_model(input int mode, input vin_t x);
    vout_t r;
    for (int i = 0; i < M; i++) begin
      case (mode)
        0:       r[i] = 8'hFF;
        1:       r[i] = 8'(i);
        default: r[i] = 8'(int'(x[i % N]) + i * 37);
      endcase
    end
    return r;
  endfunction

  function automatic vin_t ein_model(input int mode, input vin_t x);
    vin_t r;
    for (int j = 0; j < N; j++)
      r[j] = (mode == 2) ? (x[j] ^ 8'hA5) : 8'(j + 1);
    return r;
  endfunction

  function automatic int err_model(input vout_t t, input vout_t o);
    int e = 0;
    for (int i = 0; i < M; i++) begin
      int d = int'(t[i]) - int'(o[i]);
      e += (d < 0) ? -d : d;
    end
    return e;
  endfunction

  function automatic vin_t rand_in();
    vin_t r;
    for (int j = 0; j < N; j++) r[j] = 8'($urandom);
    return r;
  endfunction

  function automatic vout_t rand_out();
    vout_t r;
    for (int i = 0; i < M; i++) r[i] = 8'($urandom);
    return r;
  endfunction

  // ---------------- stub layers ----------------
  // Outputs show garbage until the strobe edge, so early sampling is visible.
  always @(posedge clk) begin
    if (bus.s_valid && bus.s_ready) bus.l_out <= rand_out();
    if (bus.l_valid && !bus.l_learn) bus.l_out <= fwd_model(stub_mode, bus.l_in);
    if (bus.l_valid && bus.l_learn) bus.l_expected_in <= ein_model(stub_mode, bus.l_in);
    else if (bus.l_valid) bus.l_expected_in <= rand_in();
  end

  assign bus3.l_out         = {M{8'h11}};
  assign bus3.l_expected_in = {N{8'h22}};

  // ---------------- single sample transaction ----------------
  task automatic do_sample(input vin_t in_v, input vout_t tgt, input logic learn,
                           input int mode, input int hold);
    int    k, guard, fwd_n, fwd_cyc, lrn_n, lrn_pair, lrn_cyc, rv_cyc, lin_bad, stable_bad;
    vout_t exp_out;
    vin_t  exp_ein;
    int    exp_err;
    exp_out = fwd_model(mode, in_v);
    exp_ein = learn ? ein_model(mode, in_v) : '0;
    exp_err = err_model(tgt, exp_out);
    @(negedge clk);
    stub_mode    = mode;
    bus.r_ready  = (hold == 0);
    bus.s_in     = in_v;
    bus.s_target = tgt;
    bus.s_learn  = learn;
    bus.s_valid  = 1'b1;
    guard = 0;
    while (!bus.s_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      check("accept_timeout", 0, 1);
      bus.s_valid = 1'b0;
      return;
    end
    @(negedge clk);
    k = 1;
    bus.s_valid  = 1'b0;
    bus.s_in     = rand_in();
    bus.s_target = rand_out();
    bus.s_learn  = 1'($urandom);
    fwd_n = 0; fwd_cyc = -1; lrn_n = 0; lrn_pair = 0; lrn_cyc = -1; rv_cyc = -1; lin_bad = 0;
    while (k < 120) begin
      if (bus.l_valid && !bus.l_learn) begin fwd_n++; fwd_cyc = k; end
      if (bus.l_learn) lrn_n++;
      if (bus.l_valid && bus.l_learn) begin lrn_pair++; lrn_cyc = k; end
      if (bus.l_in !== in_v || bus.l_expected_out !== tgt) lin_bad++;
      if (bus.r_valid) begin rv_cyc = k; break; end
      @(negedge clk);
      k++;
    end
    check("fwd_pulses", fwd_n, 1);
    check("fwd_cycle", fwd_cyc, 1);
    check("learn_level_pulses", lrn_n, learn ? 1 : 0);
    check("learn_pulses", lrn_pair, learn ? 1 : 0);
    if (learn) check("learn_cycle", lrn_cyc, 2 + LAT + M);
    check("l_in_held", lin_bad, 0);
    check("r_valid_cycle", rv_cyc, learn ? (3 + 2 * LAT + M) : (2 + LAT + M));
    if (rv_cyc < 0) return;
    check("r_error", bus.r_error, exp_err);
    check("r_out", bus.r_out, exp_out);
    check("r_expected_in", bus.r_expected_in, exp_ein);
    if (hold > 0) begin
      stable_bad = 0;
      repeat (hold) begin
        @(negedge clk);
        if (!bus.r_valid || bus.r_out !== exp_out || bus.r_error !== 13'(exp_err) ||
            bus.r_expected_in !== exp_ein || bus.s_ready || bus.l_valid) stable_bad++;
      end
      check("result_hold", stable_bad, 0);
      bus.r_ready = 1'b1;
    end
    @(negedge clk);
    check("handshake_done", {bus.r_valid, bus.s_ready}, 2'b01);
    bus.r_ready = 1'b0;
  endtask

  // ---------------- back-to-back samples ----------------
  task automatic back_to_back();
    vin_t  smp [4];
    vout_t tgt [4];
    int    errq[$];
    vin_t  held;
    int    nxt = 0, accepts = 0, results = 0, last_acc = -1, spacing_bad = 0, lin_bad = 0;
    logic  acc_seen = 1'b0, pending;
    for (int s = 0; s < 4; s++) begin smp[s] = rand_in(); tgt[s] = rand_out(); end
    @(negedge clk);
    stub_mode    = 2;
    bus.r_ready  = 1'b1;
    bus.s_learn  = 1'b0;
    bus.s_in     = smp[0];
    bus.s_target = tgt[0];
    bus.s_valid  = 1'b1;
    for (int c = 0; c < 200 && results < 4; c++) begin
      pending = 1'b0;
      if (bus.r_valid) begin
        if (errq.size() == 0) check("b2b_extra_result", 1, 0);
        else check("b2b_r_error", bus.r_error, errq.pop_front());
        results++;
      end
      if (acc_seen && bus.l_in !== held) lin_bad++;
      if (bus.s_ready && bus.s_valid) begin
        if (last_acc >= 0 && c - last_acc != 23) spacing_bad++;
        last_acc = c;
        held = smp[nxt];
        errq.push_back(err_model(tgt[nxt], fwd_model(2, smp[nxt])));
        nxt++;
        accepts++;
        pending = 1'b1;
      end
      @(negedge clk);
      if (pending) begin
        acc_seen = 1'b1;
        if (nxt < 4) begin bus.s_in = smp[nxt]; bus.s_target = tgt[nxt]; end
        else bus.s_valid = 1'b0;
      end
    end
    bus.s_valid = 1'b0;
    bus.r_ready = 1'b0;
    check("b2b_accepts", accepts, 4);
    check("b2b_results", results, 4);
    check("b2b_spacing", spacing_bad, 0);
    check("b2b_l_in_held", lin_bad, 0);
  endtask

  // ---------------- reset during WAIT_L (LAT=3 instance) ----------------
  task automatic reset_in_wait_l();
    int lrn_cyc = -1, bad = 0;
    repeat (2) @(negedge clk);
    check("r3_ready_in_reset", bus3.s_ready, 0);
    reset3 = 1'b0;
    @(negedge clk);
    bus3.s_in     = rand_in();
    bus3.s_target = rand_out();
    bus3.s_learn  = 1'b1;
    bus3.s_valid  = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      bus3.s_valid = 1'b0;
      if (bus3.l_valid && bus3.l_learn) lrn_cyc = k;
    end
    check("r3_learn_cycle", lrn_cyc, 2 + LAT3 + M);
    // Cycle 25 is the first WAIT_L cycle; reset arrives with a sample offered.
    reset3 = 1'b1;
    bus3.s_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus3.l_valid || bus3.l_learn || bus3.s_ready || bus3.r_valid) bad++;
    end
    check("r3_quiet_in_reset", bad, 0);
    reset3 = 1'b0;
    bus3.s_valid = 1'b0;
    @(negedge clk);
    check("r3_ready_after", bus3.s_ready, 1);
    check("r3_outputs_cleared",
          {bus3.l_in, bus3.l_expected_out, bus3.r_out, bus3.r_expected_in, bus3.r_error},
          '0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus3.l_valid || bus3.l_learn || bus3.r_valid) bad++;
    end
    check("r3_no_pulses_after", bad, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int bad;
    vout_t t;
    bus.s_valid = 1'b0; bus.s_in = '0; bus.s_target = '0; bus.s_learn = 1'b0;
    bus.r_ready = 1'b0;
    bus3.s_valid = 1'b0; bus3.s_in = '0; bus3.s_target = '0; bus3.s_learn = 1'b0;
    bus3.r_ready = 1'b0;

    // Reset, then five idle cycles.
    repeat (2) @(negedge clk);
    check("ready_in_reset", bus.s_ready, 0);
    reset = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!bus.s_ready || bus.l_valid || bus.l_learn || bus.r_valid) bad++;
    end
    check("idle_after_reset", bad, 0);
    check("reset_values",
          {bus.l_in, bus.l_expected_out, bus.r_out, bus.r_expected_in, bus.r_error}, '0);

    // All-ones layer output against all-zero targets, no learn.
    do_sample(rand_in(), '0, 1'b0, 0, 0);

    // Ramp output against reversed targets, learn, held result.
    for (int i = 0; i < M; i++) t[i] = 8'(18 - i);
    do_sample(rand_in(), t, 1'b1, 1, 10);

    // Randomized samples.
    for (int s = 0; s < 12; s++)
      do_sample(rand_in(), rand_out(), 1'($urandom), 2, int'($urandom_range(0, 3)));

    back_to_back();
    reset_in_wait_l();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
